lsu: RTL
========

# lsu

Load/store unit of the hxd32 execute stage, directly downstream of the ALU. It takes the ALU sum (base + offset) as the effective address and runs one data-memory transaction per instruction over a request/grant/response bus. For stores it generates byte enables and replicated write data; for loads it extracts and sign/zero-extends the returned data. It flags misaligned accesses and invalid width codes without touching the bus.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- lsu_valid_i  in  1  request from EXU; accepted when lsu_ready_o=1.
- lsu_ready_o  out  1  high only in IDLE.
- lsu_we_i  in  1  1=store, 0=load.
- lsu_funct3_i  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only).
- lsu_addr_i  in  XLEN  effective address (ALU result).
- lsu_wdata_i  in  XLEN  store data (rs2).
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_err_o  out  1  valid with lsu_done_o; 1=misaligned or invalid funct3.
- lsu_rdata_o  out  XLEN  load result, valid with lsu_done_o; held until the next done.
- dmem_req_o  out  1  bus request; held until granted.
- dmem_we_o  out  1  write strobe.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  XLEN  word address; bits [1:0] are always 00.
- dmem_wdata_o  out  XLEN  write data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  response (load data or store ack); earliest one cycle after grant.
- dmem_rdata_i  in  XLEN  load data, qualified by dmem_rvalid_i.

## Operation
- **Reset values:** FSM in IDLE; lsu_ready_o=1; all other outputs and internal registers 0.
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE:** on lsu_valid_i, register we, funct3, address and wdata, then check the request.
  - Invalid funct3 or misaligned access goes to DONE with err=1.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Invalid funct3: loads 011, 110, 111; stores ≥011.
  - Any other request goes to REQ.
- **REQ:** dmem_req_o=1 with stable addr, we, be and wdata. Go to RESP in the cycle dmem_gnt_i=1.
- **RESP:** dmem_req_o=0. Wait for dmem_rvalid_i.
  - Load: capture the extended result into lsu_rdata_o.
  - Store: lsu_rdata_o is unchanged.
  - Then go to DONE.
- **DONE:** lsu_done_o=1 for exactly one cycle, then IDLE.
  - lsu_err_o is meaningful only here.
  - On error, lsu_rdata_o is cleared to 0.
- **Byte enables** (a = addr[1:0]):
  - B/BU: 4'b0001<<a.
  - H/HU: 0011 if a[1]=0, else 1100.
  - W: 1111.
  - Loads drive the same be pattern with we=0.
- **Store data:**
  - SB: wdata[7:0] replicated ×4.
  - SH: wdata[15:0] replicated ×2.
  - SW: wdata unchanged.
- **Load extract:**
  - B/BU: byte = rdata[8a+7:8a].
  - H/HU: half = rdata[16a[1]+15:16a[1]].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- **Ignored inputs:** dmem_rvalid_i outside RESP; dmem_gnt_i outside REQ; lsu_valid_i outside IDLE.
- **Reset mid-operation:** the transaction is abandoned, dmem_req_o drops immediately (asynchronously), and no done pulse is produced.

## Timing
- **Accept:** request accepted at edge T (IDLE, lsu_valid_i=1).
  - dmem_req_o rises in cycle T+1.
  - A grant in T+1 is the earliest possible.
- **Earliest response:** rvalid in T+2; lsu_done_o in T+3; lsu_ready_o returns in T+4.
  - Minimum latency is 3 cycles to done, 4-cycle issue interval.
  - Each cycle of grant stall or response stall adds one cycle.
- **Error path:** lsu_done_o=1 with err=1 in T+1; ready in T+2; no bus activity.
- **Bus outputs:** registered from the captured request; stable throughout REQ.

## Test plan
- **LW, aligned:** LW addr 0x1000, gnt immediately, rvalid next cycle with 0xDEADBEEF.
  - Required: dmem_addr 0x1000, be=1111.
  - Required: done at T+3, rdata=0xDEADBEEF, err=0.
- **LB / LBU byte extract:** rdata 0x80FF7F01.
  - LB addr 0x1003 → 0xFFFFFF80.
  - LBU addr 0x1003 → 0x00000080.
  - LB addr 0x1001 → 0x0000007F.
  - be 1000 and 0010 respectively.
- **LH / LHU half extract:** rdata 0x8001_7FFE.
  - LH addr 0x2002 → 0xFFFF8001, be=1100.
  - LHU addr 0x2000 → 0x00007FFE, be=0011.
- **SB / SH store data:**
  - SB addr 0x3002, wdata 0x12345678 → be=0100, dmem_wdata=0x78787878, we=1.
  - SH addr 0x3002 → be=1100, dmem_wdata=0x56785678.
  - For both, done follows the ack and rdata is unchanged.
- **Misaligned:** LW addr 0x1001 and SH addr 0x1003.
  - Required: no dmem_req_o.
  - Required: done and err=1 at T+1, rdata=0.
- **Stalls and reset:**
  - gnt withheld 3 cycles: req and addr stay stable; done comes 3 cycles later.
  - rst_n_i low during RESP: dmem_req_o=0, ready=1, no done; a stray rvalid afterwards is ignored.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit for the hxd32 execute stage: one request/grant/response data-memory
// transaction per instruction, with byte-enable/replication for stores and extension for loads.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_done_o,
  output logic            lsu_err_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_err;
  logic [XLEN-1:0]   r_rdata;

  logic              w_misaligned;
  logic              w_invalid;
  logic              w_bad;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_bus_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;

  // Request check on the incoming (not yet captured) request.
  always_comb begin
    w_misaligned = 1'b0;
    w_invalid    = 1'b0;
    unique case (lsu_funct3_i)
      3'b000, 3'b100: w_misaligned = 1'b0;
      3'b001, 3'b101: w_misaligned = lsu_addr_i[0];
      3'b010:         w_misaligned = (lsu_addr_i[1:0] != 2'b00);
      default:        w_invalid    = 1'b1;
    endcase
    // BU/HU have no store counterpart.
    if (lsu_we_i && lsu_funct3_i[2]) begin
      w_invalid = 1'b1;
    end
    w_bad = w_invalid | (w_misaligned & ~w_invalid);
  end

  always_comb begin
    w_be        = 4'b1111;
    w_bus_wdata = r_wdata;
    unique case (r_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_bus_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_bus_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_bus_wdata = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    unique case (r_addr[1:0])
      2'b00: w_byte = dmem_rdata_i[7:0];
      2'b01: w_byte = dmem_rdata_i[15:8];
      2'b10: w_byte = dmem_rdata_i[23:16];
      2'b11: w_byte = dmem_rdata_i[31:24];
      default: w_byte = dmem_rdata_i[7:0];
    endcase
    w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (r_funct3[1:0])
      2'b00:   w_load_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_load_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (lsu_valid_i) w_state_d = w_bad ? StDone : StReq;
      StReq:  if (dmem_gnt_i) w_state_d = StResp;
      StResp: if (dmem_rvalid_i) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (r_state == StIdle && lsu_valid_i) begin
        r_we     <= lsu_we_i;
        r_funct3 <= lsu_funct3_i;
        r_addr   <= lsu_addr_i;
        r_wdata  <= lsu_wdata_i;
        r_err    <= w_bad;
        if (w_bad) begin
          r_rdata <= '0;
        end
      end
      if (r_state == StResp && dmem_rvalid_i && !r_we) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign lsu_ready_o  = (r_state == StIdle);
  assign lsu_done_o   = (r_state == StDone);
  assign lsu_err_o    = r_err;
  assign lsu_rdata_o  = r_rdata;
  // Strobes are gated by state so they idle low; data/address hold the captured request.
  assign dmem_req_o   = (r_state == StReq);
  assign dmem_we_o    = (r_state == StReq) & r_we;
  assign dmem_be_o    = (r_state == StReq) ? w_be : 4'b0000;
  assign dmem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata_o = w_bus_wdata;

endmodule
